// File: rtl/histogram_median_locator.sv
// Buffers one axis of histogram bins and scans them to find the median bin
// index and the total set-pixel count of each completed frame.
module histogram_median_locator #(
    parameter int NUM_BINS    = 240,
    parameter int BIN_WIDTH   = 8,
    parameter int INDEX_WIDTH = 8,
    parameter int SUM_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BIN_WIDTH-1:0]   histIn,
    input  logic                   histValid,
    input  logic                   flush,
    output logic [INDEX_WIDTH-1:0] medianIndex,
    output logic [SUM_WIDTH-1:0]   totalCount,
    output logic                   medianValid,
    output logic                   empty,
    output logic                   busy,
    output logic                   overrun
);

    localparam int ACC_W = SUM_WIDTH + 1;
    localparam logic [INDEX_WIDTH-1:0] LAST_BIN = INDEX_WIDTH'(NUM_BINS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCAN
    } stateT;

    stateT state;
    stateT nextState;

    logic [BIN_WIDTH-1:0]   buffer [NUM_BINS];
    logic [INDEX_WIDTH-1:0] wrPtr;
    logic [INDEX_WIDTH-1:0] rdPtr;
    logic [ACC_W-1:0]       sum;
    logic [ACC_W-1:0]       cum;
    logic [ACC_W-1:0]       total;
    logic [ACC_W-1:0]       target;
    logic [ACC_W-1:0]       sumNext;
    logic [ACC_W-1:0]       cumNext;
    logic                   writeEn;
    logic                   lastBeat;
    logic                   totalZero;
    logic                   scanHit;

    always_comb begin
        sumNext   = (state == IDLE) ? ACC_W'(histIn)
                                    : sum + ACC_W'(histIn);
        cumNext   = cum + ACC_W'(buffer[rdPtr]);
        target    = (total + ACC_W'(1)) >> 1;
        totalZero = (total == '0);
        writeEn   = histValid && !flush && (state != SCAN);
        lastBeat  = writeEn &&
                    (((state == IDLE) && (NUM_BINS == 1)) ||
                     ((state == LOAD) && (wrPtr == LAST_BIN)));
        scanHit   = (state == SCAN) && (totalZero || (cumNext >= target));
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (histValid) begin
                    nextState = lastBeat ? SCAN : LOAD;
                end
            end
            LOAD: begin
                if (lastBeat) begin
                    nextState = SCAN;
                end
            end
            SCAN: begin
                if (scanHit) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
        if (flush) begin
            nextState = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Bin storage carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (writeEn) begin
            buffer[wrPtr] <= histIn;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            sum         <= '0;
            cum         <= '0;
            total       <= '0;
            medianIndex <= '0;
            totalCount  <= '0;
            medianValid <= 1'b0;
            empty       <= 1'b0;
            overrun     <= 1'b0;
        end else if (flush) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            sum         <= '0;
            cum         <= '0;
            total       <= '0;
            medianIndex <= '0;
            totalCount  <= '0;
            medianValid <= 1'b0;
            empty       <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            medianValid <= 1'b0;
            if (writeEn) begin
                sum <= sumNext;
                if (lastBeat) begin
                    total <= sumNext;
                    cum   <= '0;
                    rdPtr <= '0;
                    wrPtr <= '0;
                end else begin
                    wrPtr <= wrPtr + INDEX_WIDTH'(1);
                end
            end
            if (state == SCAN) begin
                // Beats arriving while the scan runs are lost, so flag them.
                if (histValid) begin
                    overrun <= 1'b1;
                end
                if (totalZero) begin
                    medianIndex <= '0;
                    totalCount  <= '0;
                    empty       <= 1'b1;
                    medianValid <= 1'b1;
                end else if (cumNext >= target) begin
                    medianIndex <= rdPtr;
                    totalCount  <= total[SUM_WIDTH-1:0];
                    empty       <= 1'b0;
                    medianValid <= 1'b1;
                end else begin
                    cum   <= cumNext;
                    rdPtr <= rdPtr + INDEX_WIDTH'(1);
                end
            end
        end
    end

    assign busy = (state == LOAD) || (state == SCAN);

endmodule

// File: tb/tb_histogram_median_locator.sv
// Directed bench for the x (240 bin) and y (180 bin) median locators with a
// frame-level reference model compared against both every cycle.
module tb_histogram_median_locator;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    logic [7:0]  hIn [2];
    logic        hV  [2];
    logic        fl  [2];
    logic [7:0]  mIdx[2];
    logic [15:0] tCnt[2];
    logic        mV  [2];
    logic        emp [2];
    logic        bsy [2];
    logic        ovr [2];

    histogram_median_locator #(.NUM_BINS(240)) dutX (
        .clk(clk), .reset(rstN),
        .histIn(hIn[0]), .histValid(hV[0]), .flush(fl[0]),
        .medianIndex(mIdx[0]), .totalCount(tCnt[0]),
        .medianValid(mV[0]), .empty(emp[0]),
        .busy(bsy[0]), .overrun(ovr[0])
    );

    histogram_median_locator #(.NUM_BINS(180)) dutY (
        .clk(clk), .reset(rstN),
        .histIn(hIn[1]), .histValid(hV[1]), .flush(fl[1]),
        .medianIndex(mIdx[1]), .totalCount(tCnt[1]),
        .medianValid(mV[1]), .empty(emp[1]),
        .busy(bsy[1]), .overrun(ovr[1])
    );

    int nChecks = 0;
    int nErr    = 0;
    int cyc     = 0;
    int eCyc    = 0;
    int nb [2]  = '{240, 180};
    int frm [256];

    int mb [2][256];
    int mcnt [2];
    int pulseAt [2];
    int pIdx [2];
    int pTot [2];
    int pEmp [2];
    int hIdx [2];
    int hTot [2];
    int hEmp [2];
    int hOvr [2];
    int vExp [2];

    task automatic chk(input int d, input string nm, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nErr++;
            $display("FAIL dut%0d %s: got %0d expected %0d (cycle %0d)",
                     d, nm, act, exp, cyc);
        end
    endtask

    function automatic void clearModel(input int d);
        mcnt[d]    = 0;
        pulseAt[d] = -1;
        hIdx[d]    = 0;
        hTot[d]    = 0;
        hEmp[d]    = 0;
        hOvr[d]    = 0;
        vExp[d]    = 0;
    endfunction

    // Median straight from the definition: first prefix sum reaching ceil(total/2).
    function automatic void finishFrame(input int d);
        int tot;
        int tgt;
        int acc;
        int k;
        tot = 0;
        for (int i = 0; i < nb[d]; i++) tot += mb[d][i];
        tgt = (tot + 1) / 2;
        k   = 0;
        if (tot > 0) begin
            acc = 0;
            for (int i = 0; i < nb[d]; i++) begin
                acc += mb[d][i];
                if (acc >= tgt) begin
                    k = i;
                    break;
                end
            end
        end
        pIdx[d]    = k;
        pTot[d]    = tot;
        pEmp[d]    = (tot == 0) ? 1 : 0;
        pulseAt[d] = cyc + 1 + k;
        mcnt[d]    = 0;
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) clearModel(d);
        forever begin
            @(posedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                vExp[d] = 0;
                if (!rstN || fl[d]) begin
                    clearModel(d);
                end else if (pulseAt[d] >= 0) begin
                    if (hV[d]) hOvr[d] = 1;
                    if (cyc == pulseAt[d]) begin
                        hIdx[d]    = pIdx[d];
                        hTot[d]    = pTot[d];
                        hEmp[d]    = pEmp[d];
                        vExp[d]    = 1;
                        pulseAt[d] = -1;
                    end
                end else if (hV[d]) begin
                    mb[d][mcnt[d]] = int'(hIn[d]);
                    mcnt[d]++;
                    if (mcnt[d] == nb[d]) finishFrame(d);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rstN) begin
                    chk(d, "rstMedianValid", int'(mV[d]), 0);
                    chk(d, "rstMedianIndex", int'(mIdx[d]), 0);
                    chk(d, "rstTotalCount", int'(tCnt[d]), 0);
                    chk(d, "rstEmpty", int'(emp[d]), 0);
                    chk(d, "rstBusy", int'(bsy[d]), 0);
                    chk(d, "rstOverrun", int'(ovr[d]), 0);
                end else begin
                    chk(d, "medianValid", int'(mV[d]), vExp[d]);
                    chk(d, "medianIndex", int'(mIdx[d]), hIdx[d]);
                    chk(d, "totalCount", int'(tCnt[d]), hTot[d]);
                    chk(d, "empty", int'(emp[d]), hEmp[d]);
                    chk(d, "busy", int'(bsy[d]),
                        (mcnt[d] > 0 || pulseAt[d] >= 0) ? 1 : 0);
                    chk(d, "overrun", int'(ovr[d]), hOvr[d]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int d, input logic v, input logic [7:0] val);
        hV[d]  = v;
        hIn[d] = val;
        @(posedge clk);
        #2;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 256; i++) frm[i] = v;
    endtask

    task automatic sendFrame(input int d, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (gap > 0 && (i % gap) == gap - 1) drive(d, 1'b0, 8'd0);
            drive(d, 1'b1, 8'(frm[i]));
        end
        eCyc  = cyc;
        hV[d] = 1'b0;
    endtask

    task automatic waitResult(input int d, input int eIdx, input int eTot,
                              input int eEmp, input int eDelta);
        int t;
        t = 0;
        while (t < 400) begin
            @(negedge clk);
            t++;
            if (mV[d]) break;
        end
        chk(d, "resultSeen", int'(mV[d]), 1);
        chk(d, "resultLatency", cyc - eCyc, eDelta);
        chk(d, "resultIndex", int'(mIdx[d]), eIdx);
        chk(d, "resultTotal", int'(tCnt[d]), eTot);
        chk(d, "resultEmpty", int'(emp[d]), eEmp);
    endtask

    task automatic pulseFlush(input int d);
        @(posedge clk);
        #2 fl[d] = 1'b1;
        @(posedge clk);
        #2 fl[d] = 1'b0;
    endtask

    initial begin
        int pulses;
        rstN = 1'b0;
        for (int d = 0; d < 2; d++) begin
            hIn[d] = '0;
            hV[d]  = 1'b0;
            fl[d]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2 rstN = 1'b1;
        @(posedge clk);
        #2;

        fill(1);
        sendFrame(0, 240, 0);
        waitResult(0, 119, 240, 0, 120);

        fill(0);
        frm[37] = 180;
        sendFrame(0, 240, 3);
        waitResult(0, 37, 180, 0, 38);

        fill(0);
        sendFrame(0, 240, 0);
        waitResult(0, 0, 0, 1, 1);

        fill(0);
        frm[0]   = 1;
        frm[239] = 2;
        sendFrame(0, 240, 0);
        waitResult(0, 239, 3, 0, 240);

        fill(0);
        frm[179] = 240;
        sendFrame(1, 180, 0);
        waitResult(1, 179, 240, 0, 180);

        fill(1);
        sendFrame(0, 100, 0);
        pulseFlush(0);
        sendFrame(0, 240, 0);
        waitResult(0, 119, 240, 0, 120);

        sendFrame(0, 240, 0);
        for (int i = 0; i < 3; i++) drive(0, 1'b1, 8'd5);
        hV[0] = 1'b0;
        waitResult(0, 119, 240, 0, 120);
        @(negedge clk);
        chk(0, "overrunSticky", int'(ovr[0]), 1);
        pulseFlush(0);
        @(negedge clk);
        chk(0, "overrunCleared", int'(ovr[0]), 0);
        chk(0, "flushIndex", int'(mIdx[0]), 0);

        sendFrame(0, 240, 0);
        repeat (50) @(posedge clk);
        #2 rstN = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstN = 1'b1;
        pulses = 0;
        repeat (200) begin
            @(negedge clk);
            if (mV[0]) pulses++;
        end
        chk(0, "pulseAfterReset", pulses, 0);
        sendFrame(0, 240, 0);
        waitResult(0, 119, 240, 0, 120);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule

// File: doc/histogram_median_locator.md
# histogram_median_locator

Consumes one axis of the per-axis histogram readout stream (column or row counts of set pixels), buffers all bins, and locates the median bin index plus the total set-pixel count. It sits directly downstream of the histogram computation block. It is instantiated twice: once on the x stream (240 bins) and once on the y stream (180 bins). The result feeds object-position logic.

## Interface
- NUM_BINS, 240, number of bins per frame on this axis (180 for the y instance)
- BIN_WIDTH, 8, width of one histogram count
- INDEX_WIDTH, 8, width of the bin index; must satisfy 2^INDEX_WIDTH >= NUM_BINS
- SUM_WIDTH, 16, width of the total; must hold NUM_BINS*(2^BIN_WIDTH-1)
- clk  input  1  system clock, all logic on the rising edge
- reset  input  1  asynchronous, active-low reset
- histIn  input  BIN_WIDTH  bin count, in bin order starting at bin 0
- histValid  input  1  histIn is valid this cycle (one bin per beat; gaps allowed)
- flush  input  1  synchronous abort and clear (driven from the histogram clear)
- medianIndex  output  INDEX_WIDTH  median bin index of the last completed frame
- totalCount  output  SUM_WIDTH  sum of all bins of the last completed frame
- medianValid  output  1  one-cycle pulse when medianIndex and totalCount update
- empty  output  1  last completed frame had totalCount == 0
- busy  output  1  high in LOAD or SCAN
- overrun  output  1  sticky flag: a histValid beat arrived while in SCAN

## Operation
- Storage: buffer of NUM_BINS x BIN_WIDTH (inferred RAM or registers), write pointer wrPtr, read pointer rdPtr, accumulators sum and cum (SUM_WIDTH+1 bits each).
- The median is the smallest index k such that bin[0] + … + bin[k] >= target, where target = (total+1)>>1 (the ceiling of total/2), computed in SUM_WIDTH+1 bits.
- States:
  - IDLE
    - On the first histValid: write bin 0, set sum = histIn, set wrPtr = 1, go to LOAD.
    - If NUM_BINS == 1, go to SCAN instead.
  - LOAD: on each histValid, write buffer[wrPtr], add histIn to sum, increment wrPtr. The beat with wrPtr == NUM_BINS-1 is the last one: latch total = sum + histIn, clear cum and rdPtr, go to SCAN.
  - SCAN: one bin per cycle.
    - If total == 0: register medianIndex = 0, empty = 1, totalCount = 0, pulse medianValid, go to IDLE.
    - Otherwise: cumNext = cum + buffer[rdPtr].
      - If cumNext >= target: register medianIndex = rdPtr, totalCount = total, empty = 0, pulse medianValid, go to IDLE.
      - Otherwise: cum = cumNext, increment rdPtr.
- histValid in SCAN: the beat is dropped and overrun is set.
- histValid in the same cycle the scan completes: the beat is dropped and overrun is set. It does not start a new frame.
- flush (any state): next state IDLE. It clears wrPtr, rdPtr, sum, cum, overrun, medianIndex, totalCount, empty and medianValid. flush has priority over histValid in the same cycle.
- busy = (state == LOAD) or (state == SCAN).

## Timing
- Reset values: medianIndex 0, totalCount 0, medianValid 0, empty 0, busy 0, overrun 0, state IDLE. Buffer contents are don't-care.
- Let E be the edge that samples the last beat. If the median is bin k, medianValid is high from edge E+1+k to edge E+2+k. The empty frame uses k = 0.
- Worst-case latency after the last beat is NUM_BINS cycles.
- medianIndex, totalCount and empty change only together with the medianValid pulse. They hold until the next pulse, flush or reset.
- Back-to-back frames: a new frame's first beat is accepted in IDLE, i.e. from the cycle after the medianValid pulse.
- Reset or flush mid-LOAD or mid-SCAN: the partial frame is discarded and no medianValid is produced.
- Arithmetic never wraps: SUM_WIDTH+1 internal bits; at the defaults the maximum total is 61200.

## Test plan
- Reset: drive reset low mid-SCAN -> all outputs at reset values, state IDLE, no medianValid. After reset is released, a full frame completes normally.
- All 240 bins = 1 -> total 240, target 120, medianIndex 119, totalCount 240, empty 0. medianValid at E+120.
- Bin 37 = 180, all other bins 0 (x instance, with gaps in histValid) -> medianIndex 37, totalCount 180. medianValid at E+38.
- All bins 0 -> medianIndex 0, totalCount 0, empty 1. medianValid at E+1.
- Bin 0 = 1, bin 239 = 2 -> target 2, medianIndex 239, totalCount 3. y instance (NUM_BINS 180), bin 179 = 240 only -> medianIndex 179, totalCount 240.
- Robustness:
  - flush after 100 beats, then a full frame of all 1s -> one medianValid only, medianIndex 119.
  - histValid pulsed during SCAN -> overrun = 1, result unchanged; the next flush clears overrun.
